// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, issues word reads to the icache, and drives the IF/DC
// latch inputs (npc, instruction, enable). A hit that lands while decode
// is stalled is parked in a one-entry hold buffer. Branch/jump redirects
// arrive on flush/redirect_pc; halt freezes fetch until reset.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] npc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        en_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32, so 0xFFFF_FFFC steps to 0.
  assign pc_plus4 = pc + 32'd4;

  // PC, hold buffer and FSM; priority is reset, halt, flush, then normal flow.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (RST) begin
      pc        <= PC_INIT;
      state     <= FETCH;
      // NOTE: the one-entry buffer is an ordinary register, not a memory, so
      // clearing it on reset costs nothing and keeps its contents defined.
      buf_instr <= 32'h0;
    end else if (state == HALTED) begin
      // Only reset leaves HALTED; flush and halt are ignored here.
      state <= HALTED;
    end else if (halt) begin
      state <= HALTED;
    end else if (flush) begin
      // Redirect keeps redirect_pc[1:0]; the address bus masks them off.
      pc    <= redirect_pc;
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit && !stall) begin
            pc <= pc_plus4;
          end else if (ihit && stall) begin
            buf_instr <= imemload;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  // Latch-side outputs are combinational from ihit/imemload for zero-cycle delivery.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below leaves one unassigned and infers a latch.
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    instr_o  = 32'h0;
    npc_o    = 32'h0;
    valid_o  = 1'b0;
    en_o     = 1'b0;
    if (!RST) begin
      imemREN  = (state == FETCH);
      imemaddr = {pc[31:2], 2'b00};
      en_o     = flush | ~stall;
      // Bubble values unless a real delivery happens below.
      npc_o    = pc;
      if (!halt && !flush) begin
        if (state == FETCH && ihit && !stall) begin
          instr_o = imemload;
          npc_o   = pc_plus4;
          valid_o = 1'b1;
        end else if (state == HOLD && !stall) begin
          instr_o = buf_instr;
          npc_o   = pc_plus4;
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule
